// File: rtl/motion_box_detect_if.sv
// Binary motion-mask pixel stream as produced by the frame-difference
// threshold stage.
interface motion_box_detect_if;
   logic pre_img_vsync;
   logic pre_img_hsync;
   logic pre_img_valid;
   logic pre_img_bit;

   modport master (
      output pre_img_vsync,
      output pre_img_hsync,
      output pre_img_valid,
      output pre_img_bit
   );

   modport slave (
      input pre_img_vsync,
      input pre_img_hsync,
      input pre_img_valid,
      input pre_img_bit
   );
endinterface

// File: rtl/motion_box_detect.sv
// Bounding box of all foreground mask pixels in a frame, published at the
// next frame start and held for the whole following frame.
module motion_box_detect #(
   parameter logic [10:0] H_DISP     = 11'd1280,
   parameter logic [10:0] V_DISP     = 11'd720,
   parameter logic [10:0] H_OFFSET   = 11'd0,
   parameter logic [10:0] V_OFFSET   = 11'd0,
   parameter logic [20:0] MIN_PIXELS = 21'd16
) (
   input  logic                clk,
   input  logic                rst,
   motion_box_detect_if.slave  px,
   output logic                box_flag,
   output logic [10:0]         top_edge,
   output logic [10:0]         bottom_edge,
   output logic [10:0]         left_edge,
   output logic [10:0]         right_edge,
   output logic                frame_done
);

   typedef enum logic {WAIT_FRAME, COLLECT} state_t;

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [20:0] FG_MAX  = 21'h1F_FFFF;

   state_t      state, state_nxt;
   logic        vsync_d, valid_d;
   logic        vs_rise, line_end, publish, hit, box_ok;
   logic [10:0] x_cnt, y_cnt, cur_x, cur_y;
   logic [10:0] min_x, max_x, min_y, max_y;
   logic [20:0] fg_cnt;

   assign vs_rise  = px.pre_img_vsync & ~vsync_d;
   assign line_end = valid_d & ~px.pre_img_valid;

   // A pixel arriving with the frame-start edge belongs to the new frame at (0,0).
   assign cur_x = vs_rise ? 11'd0 : x_cnt;
   assign cur_y = vs_rise ? 11'd0 : y_cnt;
   assign hit   = px.pre_img_valid & px.pre_img_bit & (cur_x < H_DISP) & (cur_y < V_DISP);

   assign box_ok = (fg_cnt != 21'd0) && (fg_cnt >= MIN_PIXELS);

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      case (state)
         WAIT_FRAME: if (vs_rise) state_nxt = COLLECT;
         COLLECT:    publish = vs_rise;
         default:    state_nxt = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_FRAME;
      else     state <= state_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_d <= 1'b0;
         valid_d <= 1'b0;
         x_cnt   <= 11'd0;
         y_cnt   <= 11'd0;
         min_x   <= CNT_MAX;
         min_y   <= CNT_MAX;
         max_x   <= 11'd0;
         max_y   <= 11'd0;
         fg_cnt  <= 21'd0;
      end else begin
         vsync_d <= px.pre_img_vsync;
         valid_d <= px.pre_img_valid;
         if (vs_rise) begin
            x_cnt  <= px.pre_img_valid ? 11'd1 : 11'd0;
            y_cnt  <= 11'd0;
            min_x  <= hit ? 11'd0 : CNT_MAX;
            min_y  <= hit ? 11'd0 : CNT_MAX;
            max_x  <= 11'd0;
            max_y  <= 11'd0;
            fg_cnt <= hit ? 21'd1 : 21'd0;
         end else if (state == COLLECT) begin
            if (line_end)
               x_cnt <= 11'd0;
            else if (px.pre_img_valid && x_cnt != CNT_MAX)
               x_cnt <= x_cnt + 11'd1;
            if (line_end && y_cnt != CNT_MAX)
               y_cnt <= y_cnt + 11'd1;
            if (hit) begin
               if (cur_x < min_x) min_x <= cur_x;
               if (cur_x > max_x) max_x <= cur_x;
               if (cur_y < min_y) min_y <= cur_y;
               if (cur_y > max_y) max_y <= cur_y;
               if (fg_cnt != FG_MAX) fg_cnt <= fg_cnt + 21'd1;
            end
         end
      end
   end

   // Edges only move when a box qualifies; otherwise the last box is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         box_flag    <= 1'b0;
         top_edge    <= 11'd0;
         bottom_edge <= 11'd0;
         left_edge   <= 11'd0;
         right_edge  <= 11'd0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= publish;
         if (publish) begin
            box_flag <= box_ok;
            if (box_ok) begin
               left_edge   <= min_x + H_OFFSET;
               right_edge  <= max_x + H_OFFSET;
               top_edge    <= min_y + V_OFFSET;
               bottom_edge <= max_y + V_OFFSET;
            end
         end
      end
   end

endmodule
